// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC sequencer for the fetch/branch loop; optional BRANCH_ERRCNT_EN enables the rejected-branch counter
module branch_sequencer #(
    parameter int unsigned       SIZE     = 8,
    parameter logic [SIZE-1:0]   RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            fetchAck_i,
    input  logic            branchControl_i,
    input  logic [2:0]      programNum_i,
    input  logic            halt_i,
    output logic [SIZE-1:0] pc_o,
    output logic            fetchReq_o,
    output logic            busy_o,
    output logic            branchDone_o,
    output logic            branchErr_o,
    output logic [7:0]      errCount_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_UPDATE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic [SIZE:0]   sum_q, sum_d;
    logic            br_q, br_d;
    logic [2:0]      off_q, off_d;
    logic            halt_q, halt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [SIZE-1:0] pc_inc;
    logic            reject;

    assign pc_inc = pc_q + {{(SIZE-1){1'b0}}, 1'b1};
    // Carry/borrow out of the SIZE+1 bit sum means the target left the PC range.
    assign reject = br_q && sum_q[SIZE];

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the state-decoded fetchReq/busy outputs.
    always_comb begin
        state_d    = state_q;
        fetchReq_o = 1'b0;
        busy_o     = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetchReq_o = 1'b1;
                if (fetchAck_i) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = halt_q ? S_IDLE : S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: latch the instruction, form the target, write the PC.
    always_comb begin
        pc_d   = pc_q;
        sum_d  = sum_q;
        br_d   = br_q;
        off_d  = off_q;
        halt_d = halt_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (fetchAck_i) begin
                    br_d   = branchControl_i;
                    off_d  = programNum_i;
                    halt_d = halt_i;
                end
            end
            S_EXEC: begin
                sum_d = {1'b0, pc_q} + {{(SIZE-2){off_q[2]}}, off_q};
            end
            S_UPDATE: begin
                done_d = br_q;
                err_d  = reject;
                if (br_q && !reject) begin
                    pc_d = sum_q[SIZE-1:0];
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; latched instruction is discarded on reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q   <= RESET_PC;
            sum_q  <= '0;
            br_q   <= 1'b0;
            off_q  <= 3'd0;
            halt_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sum_q  <= sum_d;
            br_q   <= br_d;
            off_q  <= off_d;
            halt_q <= halt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign pc_o         = pc_q;
    assign branchDone_o = done_q;
    assign branchErr_o  = err_q;

`ifdef BRANCH_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Saturating count of rejected branches, stepped on the edge that raises branchErr.
    always_comb begin
        errcnt_d = errcnt_q;
        if (state_q == S_UPDATE && reject && errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Counter register; only reset clears it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            errcnt_q <= 8'd0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign errCount_o = errcnt_q;
`else
    assign errCount_o = 8'd0;
`endif

endmodule
